// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if
// Bundles the two requester ports and the shared APB bus of the arbiter.
//   req_valid/req_write/req_addr/req_wdata : per-requester request, requester r in slice r
//   req_ready                              : per-requester acceptance strobe
//   rsp_valid/rsp_rdata/rsp_err            : completion strobe and payload
//   paddr/pwrite/pwdata/psel/penable       : APB request side (driven by the arbiter)
//   prdata/pready/pslverr                  : APB completion side (driven by the slaves)
// Modport master is the arbiter view; modport slave is the environment view.
interface apb_master_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
);
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic [ADDR_W-1:0]   paddr;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [NSLV-1:0]     psel;
    logic                penable;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, pwdata, psel, penable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, pwdata, psel, penable
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Shares one APB bus between two requesters (0: bridge side, 1: config/DMA side).
// Round-robin grant, slave decode from a 2-bit address field, APB setup/access
// sequencing with a bounded pready wait and a one-cycle response strobe.
// Ports:
//   clk    : sole clock, rising edge
//   hreset : synchronous, active-high reset
//   bus    : apb_master_arbiter_if.master (requester ports + APB bus)
module apb_master_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 3,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 hreset,
    apb_master_arbiter_if.master bus
);
    localparam int WC_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t              state;
    // Index of the requester granted most recently; doubles as the index of
    // the transfer in flight, since it is updated on every acceptance.
    logic                last_grant;
    logic [WC_W-1:0]     wait_cnt;

    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [NSLV-1:0]     psel_q;
    logic                penable_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic                pick;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;
    logic [1:0]          sel_idx;

    function automatic logic [1:0] req_onehot(input logic r);
        return r ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [NSLV-1:0] slv_onehot(input logic [1:0] i);
        logic [NSLV-1:0] v;
        v = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (k == int'(i)) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Arbitration: a lone request wins; on contention the requester that was
    // not granted last wins. With nothing valid the pick still names one
    // requester so that exactly one ready bit is high while idle.
    always_comb begin
        pick      = bus.req_valid[1] & (~bus.req_valid[0] | ~last_grant);
        sel_addr  = pick ? bus.req_addr[ADDR_W +: ADDR_W]  : bus.req_addr[0 +: ADDR_W];
        sel_wdata = pick ? bus.req_wdata[DATA_W +: DATA_W] : bus.req_wdata[0 +: DATA_W];
        sel_write = bus.req_write[pick];
        sel_idx   = sel_addr[SEL_LSB +: 2];
    end

    assign bus.req_ready = (state == IDLE) ? req_onehot(pick) : 2'b00;

    always_ff @(posedge clk) begin
        if (hreset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            wait_cnt    <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                // ---- IDLE: accept, latch and decode ----
                IDLE: begin
                    if (|(bus.req_valid & bus.req_ready)) begin
                        last_grant <= pick;
                        paddr_q    <= sel_addr;
                        pwrite_q   <= sel_write;
                        pwdata_q   <= sel_wdata;
                        if (int'(sel_idx) < NSLV) begin
                            psel_q <= slv_onehot(sel_idx);
                            state  <= SETUP;
                        end else begin
                            // Unmapped slave: answer at once, never touch the bus.
                            rsp_valid_q <= req_onehot(pick);
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                // ---- SETUP: one cycle of psel without penable ----
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                // ---- ACCESS: wait for pready, bounded by TIMEOUT ----
                ACCESS: begin
                    if (bus.pready) begin
                        rsp_valid_q <= req_onehot(last_grant);
                        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                        rsp_err_q   <= bus.pslverr;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        state       <= DONE;
                    end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                        rsp_valid_q <= req_onehot(last_grant);
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // ---- DONE: response strobe visible for this one cycle ----
                DONE: begin
                    rsp_valid_q <= 2'b00;
                    wait_cnt    <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter
// Directed bench for apb_master_arbiter with a transaction-age model that
// predicts every output each cycle, plus literal expectations per scenario.
module tb_apb_master_arbiter;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NSLV    = 3;
    localparam int SEL_LSB = 12;
    localparam int TIMEOUT = 16;

    logic clk;
    logic hreset;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    bit   chk_en = 0;

    // slave behaviour knobs
    int          slv_wait = 0;
    logic [31:0] slv_rdata = 32'h0;
    bit          slv_err = 0;
    int          acc_cnt = 0;

    apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NSLV)) bus ();

    apb_master_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NSLV(NSLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .hreset(hreset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // APB slave: pready rises after slv_wait low ACCESS cycles.
    initial begin
        bus.pready  = 1'b0;
        bus.prdata  = '0;
        bus.pslverr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.psel != 0 && bus.penable) acc_cnt++;
            else acc_cnt = 0;
            bus.pready  = (acc_cnt > slv_wait);
            bus.pslverr = bus.pready & slv_err;
            bus.prdata  = slv_rdata;
        end
    end

    // Model: a transfer is tracked by its age in cycles since acceptance.
    // Age 1 is the setup cycle, ages 2.. are access cycles, and m_resp_age
    // names the cycle carrying the response once it is known.
    bit          m_busy = 0;
    bit          m_last = 1;
    bit          m_g = 0;
    int          m_age = 0;
    int          m_resp_age = 0;
    int          m_slot = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_wdata = 0;
    bit          m_wr = 0;
    logic [31:0] m_rdata = 0;
    bit          m_err = 0;

    always @(posedge clk) begin
        if (hreset) begin
            m_busy = 0; m_last = 1; m_age = 0; m_resp_age = 0;
        end else if (!m_busy) begin
            if (bus.req_valid != 2'b00) begin
                m_g     = (bus.req_valid == 2'b11) ? !m_last : bus.req_valid[1];
                m_last  = m_g;
                m_addr  = bus.req_addr[m_g*AW +: AW];
                m_wdata = bus.req_wdata[m_g*DW +: DW];
                m_wr    = bus.req_write[m_g];
                m_slot  = int'(m_addr[SEL_LSB +: 2]);
                m_busy  = 1;
                m_age   = 1;
                m_resp_age = 0;
                if (m_slot >= NSLV) begin
                    m_resp_age = 1; m_err = 1; m_rdata = 0;
                end
            end
        end else if (m_age == m_resp_age) begin
            m_busy = 0;
        end else begin
            if (m_age >= 2 && m_resp_age == 0) begin
                if (bus.pready) begin
                    m_resp_age = m_age + 1; m_err = bus.pslverr; m_rdata = m_wr ? 32'h0 : bus.prdata;
                end else if (m_age - 1 == TIMEOUT) begin
                    m_resp_age = m_age + 1; m_err = 1; m_rdata = 0;
                end
            end
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (!m_busy) begin
                chk("psel_idle", 32'(bus.psel), 32'h0);
                chk("penable_idle", 32'(bus.penable), 32'h0);
                chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'h0);
                if (bus.req_valid == 2'b11)
                    chk("req_ready_rr", 32'(bus.req_ready), m_last ? 32'h1 : 32'h2);
                else if (bus.req_valid != 2'b00)
                    chk("req_ready_single", 32'(bus.req_ready), 32'(bus.req_valid));
                else
                    chk("req_ready_onehot", 32'($onehot(bus.req_ready)), 32'h1);
            end else begin
                chk("req_ready_busy", 32'(bus.req_ready), 32'h0);
                if (m_age == m_resp_age) begin
                    chk("rsp_valid", 32'(bus.rsp_valid), m_g ? 32'h2 : 32'h1);
                    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
                    chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
                    chk("psel_rsp", 32'(bus.psel), 32'h0);
                    chk("penable_rsp", 32'(bus.penable), 32'h0);
                end else begin
                    chk("psel", 32'(bus.psel), 32'h1 << m_slot);
                    chk("penable", 32'(bus.penable), (m_age >= 2) ? 32'h1 : 32'h0);
                    chk("paddr", bus.paddr, m_addr);
                    chk("pwrite", 32'(bus.pwrite), 32'(m_wr));
                    chk("pwdata", bus.pwdata, m_wdata);
                    chk("rsp_valid_busy", 32'(bus.rsp_valid), 32'h0);
                end
            end
        end
    end

    // Present one request from requester r; returns at cycle T+1 (#1 after edge)
    // where T is the acceptance cycle.
    task automatic run_one(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 0;
        bus.req_write[r] = wr;
        bus.req_addr[r*AW +: AW] = a;
        bus.req_wdata[r*DW +: DW] = d;
        bus.req_valid[r] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.req_valid[r] && bus.req_ready[r]) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_assert++;
            n_fail++;
            $display("FAIL handshake: req_ready never seen for requester %0d", r);
        end
        @(posedge clk);
        #1;
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_assert++;
            n_fail++;
            $display("FAIL idle_wait: arbiter did not return to idle, req_ready %b", bus.req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Both requesters hold writes to slave 0; seven acceptances are taken.
    task automatic contention();
        int          hs;
        int          t[7];
        bit          g[7];
        logic [1:0]  acc;
        hs = 0;
        slv_wait = 0; slv_err = 0;
        bus.req_write = 2'b11;
        bus.req_addr  = {32'h0000_0200, 32'h0000_0100};
        bus.req_wdata = {32'hB1B1_0002, 32'hA0A0_0001};
        bus.req_valid = 2'b11;
        for (int i = 0; i < 200 && hs < 7; i++) begin
            @(negedge clk);
            if (i == 0) chk("first_grant_r0", 32'(bus.req_ready), 32'h1);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            if (acc != 2'b00) begin
                t[hs] = cyc;
                g[hs] = acc[1];
                hs++;
                if (hs >= 6) bus.req_valid = bus.req_valid & ~acc;
            end
        end
        if (hs < 7) begin
            n_assert++;
            n_fail++;
            $display("FAIL contention: only %0d acceptances", hs);
        end else begin
            for (int k = 0; k < 4; k++) chk("grant_order", 32'(g[k]), 32'(k % 2));
            for (int k = 0; k < 5; k++) chk("grant_period", 32'(t[k+2] - t[k]), 32'd8);
        end
        bus.req_valid = 2'b00;
        wait_idle();
    endtask

    initial begin
        hreset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_write = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        hreset = 1'b0;
        chk_en = 1;

        // reset state
        @(negedge clk);
        chk("rst_psel", 32'(bus.psel), 32'h0);
        chk("rst_penable", 32'(bus.penable), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk("rst_pwrite", 32'(bus.pwrite), 32'h0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        @(posedge clk);
        #1;

        contention();

        // single read, requester 0, slave 1, zero wait
        slv_wait = 0; slv_err = 0; slv_rdata = 32'hDEAD_BEEF;
        run_one(0, 1'b0, 32'h0000_1004, 32'h0);
        @(negedge clk);
        chk("rd_psel_t1", 32'(bus.psel), 32'h2);
        chk("rd_penable_t1", 32'(bus.penable), 32'h0);
        @(negedge clk);
        chk("rd_psel_t2", 32'(bus.psel), 32'h2);
        chk("rd_penable_t2", 32'(bus.penable), 32'h1);
        @(negedge clk);
        chk("rd_rsp_valid_t3", 32'(bus.rsp_valid), 32'h1);
        chk("rd_rsp_rdata_t3", bus.rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err_t3", 32'(bus.rsp_err), 32'h0);
        @(posedge clk);
        #1;
        wait_idle();

        // write, requester 1: read data returned as zero
        slv_rdata = 32'hFFFF_FFFF;
        run_one(1, 1'b1, 32'h0000_1000, 32'hCAFE_F00D);
        @(negedge clk);
        chk("wr_pwdata_t1", bus.pwdata, 32'hCAFE_F00D);
        chk("wr_pwrite_t1", 32'(bus.pwrite), 32'h1);
        repeat (2) @(negedge clk);
        chk("wr_rsp_valid_t3", 32'(bus.rsp_valid), 32'h2);
        chk("wr_rsp_rdata_t3", bus.rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        wait_idle();

        // three wait states then pslverr
        slv_wait = 3; slv_err = 1; slv_rdata = 32'h1234_5678;
        run_one(0, 1'b0, 32'h0000_2008, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("ws_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        @(negedge clk);
        chk("ws_rsp_valid_t6", 32'(bus.rsp_valid), 32'h1);
        chk("ws_rsp_err_t6", 32'(bus.rsp_err), 32'h1);
        @(posedge clk);
        #1;
        wait_idle();

        // timeout: pready never rises
        slv_wait = 1000; slv_err = 0; slv_rdata = 32'h5555_AAAA;
        run_one(1, 1'b0, 32'h0000_0010, 32'h0);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 17) chk("to_penable_t17", 32'(bus.penable), 32'h1);
        end
        chk("to_rsp_valid_t18", 32'(bus.rsp_valid), 32'h2);
        chk("to_rsp_err_t18", 32'(bus.rsp_err), 32'h1);
        chk("to_rsp_rdata_t18", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        chk("to_psel_t19", 32'(bus.psel), 32'h0);
        @(posedge clk);
        #1;
        wait_idle();

        // pready on the 16th access cycle completes normally
        slv_wait = 15;
        run_one(1, 1'b0, 32'h0000_0010, 32'h0);
        repeat (18) @(negedge clk);
        chk("to16_rsp_valid_t18", 32'(bus.rsp_valid), 32'h2);
        chk("to16_rsp_err_t18", 32'(bus.rsp_err), 32'h0);
        chk("to16_rsp_rdata_t18", bus.rsp_rdata, 32'h5555_AAAA);
        @(posedge clk);
        #1;
        wait_idle();

        // decode error: slave index 3
        slv_wait = 0;
        run_one(0, 1'b0, 32'h0000_3000, 32'h0);
        @(negedge clk);
        chk("dec_rsp_valid_t1", 32'(bus.rsp_valid), 32'h1);
        chk("dec_rsp_err_t1", 32'(bus.rsp_err), 32'h1);
        chk("dec_psel_t1", 32'(bus.psel), 32'h0);
        @(negedge clk);
        chk("dec_psel_t2", 32'(bus.psel), 32'h0);
        chk("dec_penable_t2", 32'(bus.penable), 32'h0);
        @(posedge clk);
        #1;
        wait_idle();

        // reset during an access wait state
        slv_wait = 1000;
        run_one(1, 1'b0, 32'h0000_1000, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        hreset = 1'b1;
        @(posedge clk);
        #1;
        hreset = 1'b0;
        @(negedge clk);
        chk("mrst_psel", 32'(bus.psel), 32'h0);
        chk("mrst_penable", 32'(bus.penable), 32'h0);
        chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        contention();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master that shares the single APB bus behind the AHB-to-APB bridge between the bridge-side request port (requester 0) and a secondary configuration/DMA port (requester 1). Grants one request at a time with round-robin fairness, decodes the target slave, and sequences the APB setup and access phases. Handles pready wait states with a bounded timeout and returns read data or an error to the granted requester.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NSLV, 3, number of APB slaves (width of psel)
- SEL_LSB, 12, LSB of the 2-bit slave-index field in the address
- TIMEOUT, 16, maximum ACCESS-phase cycles before abort (≥2)

Ports:
- clk  in  1  sole clock, rising edge
- hreset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid
- req_write  in  2  per-requester direction (1 = write)
- req_addr  in  2*ADDR_W  requester r at bits [r*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  requester r at bits [r*DATA_W +: DATA_W]
- req_ready  out  2  acceptance strobe; transfer occurs when req_valid[r] & req_ready[r]
- rsp_valid  out  2  one-cycle completion strobe to the granted requester
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- rsp_err  out  1  error flag, valid with rsp_valid
- paddr  out  ADDR_W  APB address
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- psel  out  NSLV  one-hot APB slave select
- penable  out  1  APB enable
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE
  - req_ready is combinational and asserted only in IDLE, for exactly one requester.
  - Only one valid: grant it. Both valid: grant the requester ≠ last_grant.
  - On acceptance, latch addr, write, wdata and grant index, and update last_grant.
  - Decode idx = addr[SEL_LSB+1:SEL_LSB]. If idx < NSLV, go to SETUP. Otherwise set err = 1 and go directly to DONE; no APB cycle is issued.
- SETUP: psel[idx] = 1, penable = 0, for one cycle, then go to ACCESS.
- ACCESS
  - psel[idx] = 1, penable = 1.
  - pready = 1: capture prdata (captured as 0 for writes) and err = pslverr, then go to DONE.
  - pready = 0: increment wait_cnt. If wait_cnt == TIMEOUT-1, abort with err = 1 and rdata = 0, then go to DONE.
- DONE: rsp_valid[grant] = 1 for one cycle with rsp_rdata and rsp_err; psel = 0, penable = 0; go to IDLE. wait_cnt clears.
- paddr, pwrite and pwdata are registered from the latched request. They hold their last value outside SETUP/ACCESS; only psel and penable qualify the bus.
- Requester rules:
  - A requester holds req_valid and its payload stable until req_ready.
  - Requests presented outside IDLE simply wait.
  - The arbiter never drops a request that is held valid.

## Timing
- Reset (hreset sampled high at an edge): state = IDLE, last_grant = 1 (so requester 0 wins the first contention), wait_cnt = 0.
- Reset values of all outputs and latched registers: paddr, pwrite, pwdata, psel, penable, rsp_valid, rsp_rdata, rsp_err all 0.
- Reset mid-transfer: the bus is released (psel = 0, penable = 0) after the reset edge, and no response is issued for the aborted transfer.
- Zero-wait-state transfer: accept at cycle T; SETUP at T+1; ACCESS at T+2 with pready = 1; rsp_valid at T+3; next accept possible at T+4. Minimum of 4 cycles per transfer.
- Each pready = 0 cycle in ACCESS adds one cycle of latency.
- ACCESS lasts at most TIMEOUT cycles. pready = 1 in the TIMEOUT-th cycle completes normally (pready takes precedence over timeout).
- Decode error: accept at T; rsp_valid with rsp_err = 1 at T+1; no psel activity.
- rsp_valid is never asserted to both requesters in the same cycle.
- req_ready is never asserted while rsp_valid is high.

## Test plan
- Single read, requester 0: addr 0x0000_1004 (idx 1), pready = 1 on the first ACCESS cycle, prdata = 0xDEAD_BEEF -> psel = 3'b010 at T+1/T+2, penable only at T+2, rsp_valid = 2'b01 at T+3, rsp_rdata = 0xDEAD_BEEF, rsp_err = 0.
- Contention: both requesters valid continuously with writes to idx 0 -> grants alternate 0,1,0,1 starting with 0; pwdata matches each requester's wdata; each requester receives rsp_valid every 8 cycles.
- Wait states: pready held low for 3 ACCESS cycles, then high with pslverr = 1 -> response at T+6 with rsp_err = 1.
- Timeout: TIMEOUT = 16, pready never asserted -> ACCESS lasts exactly 16 cycles, rsp_err = 1, rsp_rdata = 0, psel = 0 afterwards. A variant with pready = 1 on cycle 16 -> normal completion, rsp_err = 0.
- Decode error: addr 0x0000_3000 (idx 3) with NSLV = 3 -> no psel or penable, rsp_valid at T+1 with rsp_err = 1.
- Reset mid-ACCESS: hreset = 1 during a wait state -> psel, penable, rsp_valid all 0 after the edge. The next contention after reset grants requester 0.
